// File: rtl/pe_cfg_loader_pkg.sv
// Shared types, field positions and helpers for the PE configuration loader.
package pe_cfg_pkg;

    localparam int CFG_W     = 33;
    localparam int DATA_W    = 36;
    localparam int BUFCFG_HI = 24;
    localparam int BUFCFG_LO = 22;
    localparam int VALID_BIT = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DAT  = 2'd2,
        FIN  = 2'd3
    } state_t;

    function automatic logic [1:0] popcount3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

endpackage

// File: rtl/pe_cfg_loader_if.sv
// Config-word stream handshake between the host/config memory and the loader.
interface pe_cfg_loader_if;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;

    modport master (output in_data, output in_valid, input  in_ready);
    modport slave  (input  in_data, input  in_valid, output in_ready);
endinterface

// File: rtl/pe_cfg_loader_demux.sv
// Registered steering of one config word to the selected PE slice; all other
// slices (valid bit included) are driven to zero every cycle.
module pe_cfg_demux
    import pe_cfg_pkg::*;
#(
    parameter int NUM_PE   = 3,
    parameter int PE_IDX_W = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      fire,
    input  logic [PE_IDX_W-1:0]       idx,
    input  logic [31:0]               word,
    output logic [NUM_PE*CFG_W-1:0]   cfg_out
);

    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_out <= '0;
        end else begin
            for (int i = 0; i < NUM_PE; i++) begin
                if (fire && (idx == PE_IDX_W'(i)))
                    cfg_out[i*CFG_W +: CFG_W] <= {1'b1, word};
                else
                    cfg_out[i*CFG_W +: CFG_W] <= '0;
            end
        end
    end

endmodule

// File: rtl/pe_cfg_loader.sv
// Sequences header + buffer-init words into each PE of a row, PE 0 first.
// Optional word counter output enabled by PE_CFG_LOADER_WORD_CNT_EN.
//
// state | meaning
// IDLE  | waiting for start
// HDR   | expecting the header word for PE pe_idx
// DAT   | expecting buffer-init words for PE pe_idx (remaining > 0)
// FIN   | one-cycle done pulse, then back to IDLE
module pe_cfg_loader
    import pe_cfg_pkg::*;
#(
    parameter int NUM_PE   = 3,
    parameter int PE_IDX_W = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      abort,
    pe_cfg_loader_if.slave            in_bus,
    output logic [NUM_PE*CFG_W-1:0]   cfg_out,
    output logic                      busy,
    output logic                      done,
    output logic                      err
`ifdef PE_CFG_LOADER_WORD_CNT_EN
   ,output logic [15:0]               word_cnt
`endif
);

    localparam logic [PE_IDX_W-1:0] LAST_IDX = PE_IDX_W'(NUM_PE - 1);

    state_t                state, state_nxt;
    logic [PE_IDX_W-1:0]   pe_idx, pe_idx_nxt;
    logic [1:0]            remaining, remaining_nxt;
    logic                  err_nxt;
    logic                  fire;
    logic                  start_ok;

    assign in_bus.in_ready = (state == HDR) || (state == DAT);
    assign fire            = in_bus.in_valid && in_bus.in_ready;
    assign start_ok        = (state == IDLE) && start;
    assign busy            = (state == HDR) || (state == DAT);
    // An abort landing in FIN suppresses the pulse: aborted passes never report done.
    assign done            = (state == FIN) && !abort;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pe_idx    <= '0;
            remaining <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            pe_idx    <= pe_idx_nxt;
            remaining <= remaining_nxt;
            err       <= err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pe_idx_nxt    = pe_idx;
        remaining_nxt = remaining;
        err_nxt       = err;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt  = HDR;
                    pe_idx_nxt = '0;
                    err_nxt    = 1'b0;
                end
            end
            HDR: begin
                if (fire) begin
                    remaining_nxt = popcount3(in_bus.in_data[BUFCFG_HI:BUFCFG_LO]);
                    if (remaining_nxt != 2'd0)
                        state_nxt = DAT;
                    else if (pe_idx == LAST_IDX)
                        state_nxt = FIN;
                    else
                        pe_idx_nxt = pe_idx + 1'b1;
                end
            end
            DAT: begin
                if (fire) begin
                    remaining_nxt = remaining - 2'd1;
                    if (remaining == 2'd1) begin
                        if (pe_idx == LAST_IDX) begin
                            state_nxt = FIN;
                        end else begin
                            state_nxt  = HDR;
                            pe_idx_nxt = pe_idx + 1'b1;
                        end
                    end
                end
            end
            FIN: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Abort wins the state change; a word transferring this cycle still goes out.
        if (abort && (state != IDLE)) begin
            state_nxt = IDLE;
            err_nxt   = 1'b1;
        end
    end

    pe_cfg_demux #(
        .NUM_PE   (NUM_PE),
        .PE_IDX_W (PE_IDX_W)
    ) u_demux (
        .clk     (clk),
        .reset   (reset),
        .fire    (fire),
        .idx     (pe_idx),
        .word    (in_bus.in_data),
        .cfg_out (cfg_out)
    );

`ifdef PE_CFG_LOADER_WORD_CNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            word_cnt <= '0;
        else if (start_ok)
            word_cnt <= '0;
        else if (fire && (word_cnt != 16'hFFFF))
            word_cnt <= word_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_pe_cfg_loader.sv
// Directed self-checking bench for pe_cfg_loader with NUM_PE=3.
module tb_pe_cfg_loader;
    localparam int NUM_PE = 3;
    localparam int W      = NUM_PE * 33;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic           abort;
    logic [W-1:0]   cfg_out;
    logic           busy;
    logic           done;
    logic           err;
`ifdef PE_CFG_LOADER_WORD_CNT_EN
    logic [15:0]    word_cnt;
`endif

    int errors = 0;
    int checks = 0;

    pe_cfg_loader_if bus();

    pe_cfg_loader #(.NUM_PE(NUM_PE), .PE_IDX_W(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .abort   (abort),
        .in_bus  (bus),
        .cfg_out (cfg_out),
        .busy    (busy),
        .done    (done),
        .err     (err)
`ifdef PE_CFG_LOADER_WORD_CNT_EN
       ,.word_cnt(word_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] slice(input int i, input logic [31:0] w);
        logic [W-1:0] v;
        v = '0;
        v[i*33 +: 33] = {1'b1, w};
        return v;
    endfunction

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Present one word for one cycle and check the resulting slice and done.
    task automatic send(input string tag, input logic [31:0] w, input int idx, input logic last);
        bus.in_data  = w;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk({tag, "_cfg"}, cfg_out, slice(idx, w));
        chk({tag, "_done"}, done, last);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        bus.in_data = '0; bus.in_valid = 1'b0;
        tick(); tick();
        chk("rst_cfg",   cfg_out, '0);
        chk("rst_ready", bus.in_ready, 1'b0);
        chk("rst_busy",  busy, 1'b0);
        chk("rst_done",  done, 1'b0);
        chk("rst_err",   err, 1'b0);
        reset = 1'b0;
        tick();

        // Scenario 1: mixed buffer_config, in_valid held high, back-to-back
        pulse_start();
        chk("s1_busy", busy, 1'b1);
        chk("s1_ready", bus.in_ready, 1'b1);
        send("s1_w0", 32'h0105A888, 0, 1'b0);
        send("s1_w1", 32'h00000008, 0, 1'b0);
        send("s1_w2", 32'h0145A888, 1, 1'b0);
        send("s1_w3", 32'h0000000A, 1, 1'b0);
        send("s1_w4", 32'h0000000A, 1, 1'b0);
        send("s1_w5", 32'h0145A888, 2, 1'b0);
        send("s1_w6", 32'h0000000A, 2, 1'b0);
        send("s1_w7", 32'h0000000A, 2, 1'b1);
        chk("s1_ready_fin", bus.in_ready, 1'b0);
        chk("s1_busy_fin", busy, 1'b0);
`ifdef PE_CFG_LOADER_WORD_CNT_EN
        chk("s1_wcnt", word_cnt, 16'd8);
`endif
        tick();
        chk("s1_idle_cfg", cfg_out, '0);
        chk("s1_idle_done", done, 1'b0);
        chk("s1_idle_ready", bus.in_ready, 1'b0);
`ifdef PE_CFG_LOADER_WORD_CNT_EN
        pulse_start();
        chk("wcnt_clr", word_cnt, 16'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
`endif

        // Scenario 2: headers only
        pulse_start();
        chk("s2_err_clr", err, 1'b0);
        send("s2_h0", 32'h0005A888, 0, 1'b0);
        send("s2_h1", 32'h0005A888, 1, 1'b0);
        send("s2_h2", 32'h0005A888, 2, 1'b1);
        tick();

        // Abort while idle has no effect
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("idle_abort_err", err, 1'b0);
        chk("idle_abort_busy", busy, 1'b0);

        // Scenario 3: stall between PE1 header and its data; start while busy ignored
        pulse_start();
        send("s3_h0", 32'h0005A888, 0, 1'b0);
        send("s3_h1", 32'h0145A888, 1, 1'b0);
        start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            start = 1'b0;
            chk("s3_stall_cfg", cfg_out, '0);
            chk("s3_stall_busy", busy, 1'b1);
            chk("s3_stall_ready", bus.in_ready, 1'b1);
        end
        send("s3_d0", 32'h00000011, 1, 1'b0);
        send("s3_d1", 32'h00000022, 1, 1'b0);
        send("s3_h2", 32'h0005A888, 2, 1'b1);
        tick();

        // Scenario 4: abort during PE1 data, then restart
        pulse_start();
        send("s4_h0", 32'h0005A888, 0, 1'b0);
        send("s4_h1", 32'h0145A888, 1, 1'b0);
        send("s4_d0", 32'h00000033, 1, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("s4_busy", busy, 1'b0);
        chk("s4_err", err, 1'b1);
        chk("s4_done", done, 1'b0);
        chk("s4_cfg", cfg_out, '0);
        tick();
        chk("s4_err_sticky", err, 1'b1);
        chk("s4_ready", bus.in_ready, 1'b0);
        pulse_start();
        chk("s4_err_clr", err, 1'b0);
        chk("s4_busy2", busy, 1'b1);
        send("s4_r0", 32'h0005A888, 0, 1'b0);
        send("s4_r1", 32'h0005A888, 1, 1'b0);
        send("s4_r2", 32'h0005A888, 2, 1'b1);
        tick();

        // Scenario 5: reset mid-pass with simultaneous start
        pulse_start();
        send("s5_h0", 32'h0105A888, 0, 1'b0);
        send("s5_d0", 32'h00000044, 0, 1'b0);
        bus.in_data  = 32'h0145A888;
        bus.in_valid = 1'b1;
        reset = 1'b1;
        start = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        reset = 1'b0;
        start = 1'b0;
        chk("s5_rst_cfg", cfg_out, '0);
        chk("s5_rst_busy", busy, 1'b0);
        chk("s5_rst_ready", bus.in_ready, 1'b0);
        chk("s5_rst_err", err, 1'b0);
        tick();
        chk("s5_no_start", busy, 1'b0);
        pulse_start();
        send("s5_r0", 32'h0005A888, 0, 1'b0);
        send("s5_r1", 32'h0105A888, 1, 1'b0);
        send("s5_r1d", 32'h00000055, 1, 1'b0);
        send("s5_r2", 32'h0005A888, 2, 1'b1);
        tick();
        chk("s5_end_busy", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pe_cfg_loader.md
Name: pe_cfg_loader

Overview:
- Upstream configuration sequencer for a row of PE_top instances.
- Accepts a 32-bit config-word stream from the host or config memory over a valid/ready handshake.
- Drives each PE's 33-bit PE_Configure_Inport, where bit 32 is the valid flag and bits 31:0 are the payload.
- Per PE, in index order 0..NUM_PE-1, it sends one header word, then as many buffer-init words as the header's buffer_config field has set bits.

Parameters:
- NUM_PE, 3, number of PEs programmed; 1..16.
- PE_IDX_W, 4, width of the PE index counter; must satisfy 2**PE_IDX_W >= NUM_PE.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a programming pass when idle.
- abort  input  1  terminates the pass immediately.
- in_data  input  32  config word.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts in_data this cycle.
- cfg_out  output  NUM_PE*33  PE i's configure port is slice [i*33+32 : i*33].
- busy  output  1  pass in progress.
- done  output  1  one-cycle pulse when all PEs have been programmed.
- err  output  1  sticky; set by abort during a pass, cleared by reset or the next start.

Behaviour:
- Header payload layout:
  - [31:25] null
  - [24:22] buffer_config
  - [21] inport0_valid
  - [20:16] alu
  - [15:13] buf_mode
  - [12:9] buf_from
  - [8:7] bypass
  - [6] outmode
  - [5:2] control
  - [1:0] branch_control
- The loader decodes only buffer_config. Data word count = popcount(buffer_config), 0..3.
- Reset values: cfg_out=0, in_ready=0, busy=0, done=0, err=0, state=IDLE, pe_idx=0, remaining-word counter=0.
- Handshake: a word transfers when in_valid && in_ready. in_ready=1 only in HDR and DAT.
- Latency: a word accepted at edge N appears at edge N+1 on slice pe_idx, with bit 32=1, for exactly one cycle.
- Every slice not receiving a word in a given cycle is driven to all-zero, including bit 32.
- Stall: if in_valid=0 in HDR or DAT, the target slice is all-zero that cycle and state holds. There is no timeout.
- FSM states and transitions:
  - IDLE: on start, go to HDR; pe_idx=0, busy=1, err=0.
  - HDR: on transfer, emit the header; remaining = popcount(in_data[24:22]).
    - If remaining>0, go to DAT.
    - Else if pe_idx==NUM_PE-1, go to FIN.
    - Else pe_idx++ and stay in HDR.
  - DAT: on transfer, emit the word and decrement remaining.
    - When it reaches 0: if the last PE, go to FIN; else pe_idx++ and go to HDR.
  - FIN: one cycle; done=1, busy=0; then go to IDLE.
- The last word's cfg_out pulse and the done pulse occur in the same cycle.
- Back-to-back transfers are supported: one word per cycle, no bubbles between PEs.
- Boundaries:
  - start while busy: ignored.
  - start and reset in the same cycle: reset wins.
  - abort in any non-IDLE state: go to IDLE next edge; busy=0, err=1, no done pulse.
    - A word transferring in that same cycle is still emitted; abort has priority for the state change.
  - abort in IDLE: no effect.
  - buffer_config=3'b000: PE receives only its header.
  - Reset mid-pass: all state and outputs return to reset values next edge; partial PE programming is abandoned.
  - pe_idx never wraps; a pass ends at NUM_PE-1.

Optional Feature:
- Macro PE_CFG_LOADER_WORD_CNT_EN.
- When defined: adds output word_cnt (16 bits), the number of words emitted in the current or last pass.
  - Reset to 0, and cleared on an accepted start.
  - Increments on each transfer and saturates at 16'hFFFF.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Decomposition:
- Shared package pe_cfg_pkg holds:
  - CFG_W=33 and DATA_W=36.
  - Field position localparams: BUFCFG_HI=24, BUFCFG_LO=22, VALID_BIT=32.
  - State enum: IDLE, HDR, DAT, FIN.
  - popcount3 function.
- One natural sub-module, pe_cfg_demux: registered one-hot steering of a 33-bit word to slice pe_idx, all other slices zeroed.

Test Plan:
- NUM_PE=3. Stream 0x0105A888 (buffer_config=100), 8, 0x0145A888 (101), 10, 10, 0x0145A888, 10, 10 with in_valid held high → slice 0 gets {1,0x0105A888} then {1,8}; slices 1 and 2 each get a header then two {1,10} on consecutive cycles; done on the 8th output cycle; in_ready low afterwards.
- All three headers with buffer_config=000 (e.g. 0x0005A888) → three single-cycle pulses on slices 0,1,2 in consecutive cycles; done coincides with slice 2's pulse.
- Deassert in_valid for 3 cycles between PE1's header and its first data word → slice 1 is zero for 3 cycles; state stays DAT; resumes with no word lost or duplicated.
- abort asserted during PE1 DAT → next cycle busy=0, err=1, no done, cfg_out all-zero; a following start clears err and restarts at PE0.
- reset asserted mid-pass after PE0 completes → all outputs zero next edge; start then reprograms from PE0.
- With PE_CFG_LOADER_WORD_CNT_EN defined, the first scenario → word_cnt=8 after done; a new start resets it to 0.
